// File: rtl/blink_period_meter.sv
// Measures the half-period of a slow square wave in whole milliseconds. It synchronizes and
// deglitches the input, times successive toggles and flags a timeout when toggling stops.
module blink_period_meter #(
  parameter int CLK_PER_MS = 50000,
  parameter int MS_W       = 12,
  parameter int FILT_LEN   = 4,
  parameter int TIMEOUT_MS = 4000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sig_in,
  input  logic            clr,
  output logic [MS_W-1:0] ms_val,
  output logic            ms_vld,
  output logic            meas_ok,
  output logic            timeout
);

  localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  typedef enum logic {IDLE, ARMED} state_t;

  state_t          state;
  logic            s_meta;
  logic            s_sync;
  logic            filt;
  logic            filt_d;
  logic            edge_r;
  logic [FW-1:0]   fcnt;
  logic [PW-1:0]   presc;
  logic [MS_W-1:0] ms_cnt;

  logic filt_chg;
  logic tick;
  logic tmo_hit;

  assign filt_chg = filt ^ filt_d;
  assign tick     = (presc == PW'(CLK_PER_MS - 1));
  assign tmo_hit  = tick && (ms_cnt == MS_W'(TIMEOUT_MS - 1));

  // Input front end: 2-FF synchronizer, run-length filter and registered edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      fcnt   <= '0;
      edge_r <= 1'b0;
    end else begin
      // NOTE: every sequential assignment is non-blocking so all registers update from
      // the same pre-edge values and the pipeline stages cannot race each other.
      s_meta <= sig_in;
      s_sync <= s_meta;
      if (s_sync != filt) begin
        if (fcnt == FW'(FILT_LEN - 1)) begin
          filt <= ~filt;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
      filt_d <= filt;
      edge_r <= filt_chg;
    end
  end

  // Interval timer and measurement FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      presc   <= '0;
      ms_cnt  <= '0;
      ms_val  <= '0;
      ms_vld  <= 1'b0;
      meas_ok <= 1'b0;
      timeout <= 1'b0;
    end else begin
      ms_vld <= 1'b0;
      if (clr) begin
        state   <= IDLE;
        presc   <= '0;
        ms_cnt  <= '0;
        ms_val  <= '0;
        meas_ok <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ms_cnt <= '0;
            if (edge_r) begin
              state   <= ARMED;
              timeout <= 1'b0;
              presc   <= PW'(1);
            end else begin
              presc <= '0;
            end
          end
          ARMED: begin
            // NOTE: the prescaler restarts one cycle ahead of the edge strobe, so it reads 0
            // in the edge cycle itself; an N-cycle interval then holds floor(N/CLK_PER_MS) ticks.
            presc <= (filt_chg || tick) ? '0 : presc + 1'b1;
            if (edge_r) begin
              ms_val  <= ms_cnt;
              ms_vld  <= 1'b1;
              meas_ok <= 1'b1;
              ms_cnt  <= '0;
            end else if (tmo_hit) begin
              timeout <= 1'b1;
              meas_ok <= 1'b0;
              ms_cnt  <= '0;
              presc   <= '0;
              state   <= IDLE;
            end else if (tick) begin
              ms_cnt <= ms_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blink_period_meter.sv
// Self-checking bench for blink_period_meter: expected measurements are queued when a toggle
// is driven and compared when ms_vld fires; scenario tasks check timing, timeout, clr and rst.
module tb_blink_period_meter;

  localparam int CLK_PER_MS = 50;
  localparam int MS_W       = 12;
  localparam int FILT_LEN   = 4;
  localparam int TIMEOUT_MS = 8;
  localparam int LAT_VLD    = 2 + FILT_LEN + 1;

  logic            clk    = 1'b0;
  logic            rst    = 1'b1;
  logic            sig_in = 1'b0;
  logic            clr    = 1'b0;
  logic [MS_W-1:0] ms_val;
  logic            ms_vld;
  logic            meas_ok;
  logic            timeout;

  int              n_checks = 0;
  int              n_pass   = 0;
  int              prev_gap = 0;
  int              vld_seen = 0;
  logic            prev_vld = 1'b0;
  logic [MS_W-1:0] sb_exp;
  logic [MS_W-1:0] sb_q[$];

  always #5 clk = ~clk;

  blink_period_meter #(
    .CLK_PER_MS(CLK_PER_MS),
    .MS_W      (MS_W),
    .FILT_LEN  (FILT_LEN),
    .TIMEOUT_MS(TIMEOUT_MS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .clr    (clr),
    .ms_val (ms_val),
    .ms_vld (ms_vld),
    .meas_ok(meas_ok),
    .timeout(timeout)
  );

  // Scoreboard: each strobe pops the oldest expected measurement.
  always @(negedge clk) begin
    if (ms_vld === 1'b1) begin
      vld_seen++;
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected_vld: got ms_val=%0d, expected no strobe", ms_val);
      end else begin
        sb_exp = sb_q.pop_front();
        if (ms_val !== sb_exp)
          $display("FAIL sb_ms_val: got %0d, expected %0d", ms_val, sb_exp);
        else
          n_pass++;
      end
      n_checks++;
      if (prev_vld === 1'b1)
        $display("FAIL vld_back_to_back: got ms_vld high 2 cycles, expected single-cycle strobe");
      else
        n_pass++;
    end
    prev_vld = ms_vld;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Toggle sig_in, queue the expected result of the interval just closed, check strobe timing,
  // then idle so the next toggle lands exactly gap cycles later.
  task automatic send_toggle(input int gap, input bit arm_only, input string name);
    sig_in = ~sig_in;
    if (!arm_only) sb_q.push_back(MS_W'(prev_gap / CLK_PER_MS));
    repeat (LAT_VLD) @(negedge clk);
    n_checks++;
    if (ms_vld !== 1'b0) $display("FAIL %s_early_vld: got ms_vld=%b, expected 0", name, ms_vld);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ms_vld !== !arm_only)
      $display("FAIL %s_vld_timing: got ms_vld=%b, expected %b", name, ms_vld, !arm_only);
    else n_pass++;
    n_checks++;
    if (meas_ok !== !arm_only)
      $display("FAIL %s_meas_ok: got %b, expected %b", name, meas_ok, !arm_only);
    else n_pass++;
    n_checks++;
    if (timeout !== 1'b0) $display("FAIL %s_timeout: got %b, expected 0", name, timeout);
    else n_pass++;
    repeat (gap - LAT_VLD - 1) @(negedge clk);
    prev_gap = gap;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ms_val, ms_vld, meas_ok, timeout} !== '0)
        $display("FAIL reset_outputs: got val=%0d vld=%b ok=%b to=%b, expected all 0",
                 ms_val, ms_vld, meas_ok, timeout);
      else n_pass++;
      sig_in = ~sig_in;
    end
    rst    = 1'b0;
    sig_in = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if ({ms_val, ms_vld, meas_ok, timeout} !== '0)
      $display("FAIL post_reset_idle: got val=%0d vld=%b ok=%b to=%b, expected all 0",
               ms_val, ms_vld, meas_ok, timeout);
    else n_pass++;
  endtask

  task automatic test_period();
    send_toggle(250, 1'b1, "period_arm");
    send_toggle(250, 1'b0, "period_2");
    send_toggle(250, 1'b0, "period_3");
  endtask

  task automatic test_rounding();
    send_toggle(249, 1'b0, "round_250");
    send_toggle(50,  1'b0, "round_249");
    send_toggle(49,  1'b0, "round_50");
    send_toggle(399, 1'b0, "round_49");
  endtask

  task automatic test_timeout();
    sig_in = ~sig_in;
    sb_q.push_back(MS_W'(prev_gap / CLK_PER_MS));
    repeat (TIMEOUT_MS * CLK_PER_MS + LAT_VLD - 1) @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0 || meas_ok !== 1'b1)
      $display("FAIL timeout_early: got to=%b ok=%b, expected to=0 ok=1", timeout, meas_ok);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (timeout !== 1'b1 || meas_ok !== 1'b0)
      $display("FAIL timeout_set: got to=%b ok=%b, expected to=1 ok=0", timeout, meas_ok);
    else n_pass++;
    n_checks++;
    if (ms_val !== MS_W'(TIMEOUT_MS - 1))
      $display("FAIL timeout_val_hold: got %0d, expected %0d", ms_val, TIMEOUT_MS - 1);
    else n_pass++;
    repeat (50) @(negedge clk);
    send_toggle(120, 1'b1, "timeout_rearm");
    send_toggle(60,  1'b0, "timeout_meas");
  endtask

  task automatic test_clr();
    sig_in = ~sig_in;
    repeat (LAT_VLD) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (ms_vld !== 1'b0 || ms_val !== '0 || meas_ok !== 1'b0)
      $display("FAIL clr_beats_edge: got vld=%b val=%0d ok=%b, expected 0 0 0",
               ms_vld, ms_val, meas_ok);
    else n_pass++;
    repeat (100 - LAT_VLD - 1) @(negedge clk);
    send_toggle(100, 1'b1, "clr_rearm");
    send_toggle(100, 1'b0, "clr_meas");
  endtask

  task automatic test_rst_mid();
    repeat (100) @(negedge clk);
    rst    = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ms_val, ms_vld, meas_ok, timeout} !== '0)
        $display("FAIL rst_mid_outputs: got val=%0d vld=%b ok=%b to=%b, expected all 0",
                 ms_val, ms_vld, meas_ok, timeout);
      else n_pass++;
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    send_toggle(100, 1'b1, "rst_rearm");
    send_toggle(30,  1'b0, "rst_meas");
  endtask

  task automatic test_glitch();
    int base;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (meas_ok !== 1'b0 || ms_val !== '0)
      $display("FAIL glitch_clr: got ok=%b val=%0d, expected 0 0", meas_ok, ms_val);
    else n_pass++;
    base   = vld_seen;
    sig_in = 1'b1;
    repeat (FILT_LEN - 1) @(negedge clk);
    sig_in = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (vld_seen !== base)
      $display("FAIL glitch_rejected: got %0d strobes, expected 0", vld_seen - base);
    else n_pass++;
    sb_q.push_back(MS_W'(FILT_LEN / CLK_PER_MS));
    sig_in = 1'b1;
    repeat (FILT_LEN) @(negedge clk);
    sig_in = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (vld_seen !== base + 1)
      $display("FAIL pulse_accepted: got %0d strobes, expected 1", vld_seen - base);
    else n_pass++;
    n_checks++;
    if (meas_ok !== 1'b1) $display("FAIL pulse_meas_ok: got %b, expected 1", meas_ok);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_period();
    test_rounding();
    test_timeout();
    test_clr();
    test_rst_mid();
    test_glitch();
    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL sb_drain: got %0d pending results, expected 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
